// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - Single-outstanding data-bus responder with fixed-latency backing store
//
// Purpose:
//   Accepts one request at a time on a valid/addr_ok handshake, waits a fixed
//   LATENCY cycles, then completes it with a one-cycle data_ok pulse. Reads
//   return the full stored word; writes update only the strobed byte lanes.
//
// Parameters:
//   DEPTH_LOG2    log2 of the number of 32-bit words in the backing store
//   LATENCY       cycles from handshake to data_ok (1..15)
//
// Ports:
//   clk           sole clock, rising edge
//   resetn        asynchronous active-low reset
//   dreq_valid    request present
//   dreq_addr     byte address; word index is addr[DEPTH_LOG2+1:2], other bits ignored
//   dreq_size     access size code, informational only
//   dreq_strobe   byte-lane write enables; all-zero means read
//   dreq_data     lane-aligned write data
//   dresp_addr_ok request accepted this cycle (combinational in IDLE)
//   dresp_data_ok transaction complete this cycle
//   dresp_data    read data while dresp_data_ok, otherwise 0
//   busy          a transaction is outstanding

module dbus_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dreq_valid,
    input  logic [31:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [3:0]  dreq_strobe,
    input  logic [31:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [31:0] dresp_data,
    output logic        busy
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [3:0]            strobe_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  data_ok_q;
    logic                  busy_q;

    // Backing store: deliberately not reset.
    logic [31:0]           mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  handshake;
    logic                  unused_bits;

    assign req_idx   = dreq_addr[DEPTH_LOG2+1:2];
    assign handshake = dreq_valid && dresp_addr_ok;

    // Address bits outside the word index and the size code do not affect behaviour.
    assign unused_bits = ^{dreq_size, dreq_addr[31:DEPTH_LOG2+2], dreq_addr[1:0]};

    // Gated by resetn so the handshake is suppressed while reset is held.
    assign dresp_addr_ok = resetn && (state_q == IDLE) && dreq_valid;
    assign dresp_data_ok = data_ok_q;
    assign dresp_data    = rdata_q;
    assign busy          = busy_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            strobe_q  <= 4'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            data_ok_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        idx_q    <= req_idx;
                        strobe_q <= dreq_strobe;
                        wdata_q  <= dreq_data;
                        busy_q   <= 1'b1;
                        if (LATENCY == 1) begin
                            // Storage is only written at the end of RESP and only one
                            // transaction is ever in flight, so the array is current here.
                            state_q   <= RESP;
                            data_ok_q <= 1'b1;
                            rdata_q   <= (dreq_strobe == 4'd0) ? mem_q[req_idx] : 32'd0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q   <= RESP;
                        data_ok_q <= 1'b1;
                        rdata_q   <= (strobe_q == 4'd0) ? mem_q[idx_q] : 32'd0;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    data_ok_q <= 1'b0;
                    busy_q    <= 1'b0;
                    rdata_q   <= 32'd0;
                end
                default: begin
                    state_q   <= IDLE;
                    data_ok_q <= 1'b0;
                    busy_q    <= 1'b0;
                    rdata_q   <= 32'd0;
                end
            endcase
        end
    end

    // Write commits on the edge that ends RESP. Reset forces state_q to IDLE
    // asynchronously, so an interrupted write never reaches this point.
    always_ff @(posedge clk) begin
        if (state_q == RESP && strobe_q != 4'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, log2 of backing-store words.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from accepted request to data_ok; legal range 1..15.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port resetn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port dreq_valid  in  1  request present.
REQ-006 SHALL have port dreq_addr  in  32  byte address.
REQ-007 SHALL have port dreq_size  in  3  access size code (0=byte, 1=half, 2=word); informational only.
REQ-008 SHALL have port dreq_strobe  in  4  byte-lane write enables; all-zero means read.
REQ-009 SHALL have port dreq_data  in  32  write data, lane-aligned.
REQ-010 SHALL have port dresp_addr_ok  out  1  request accepted this cycle.
REQ-011 SHALL have port dresp_data_ok  out  1  transaction complete this cycle.
REQ-012 SHALL have port dresp_data  out  32  read data, valid when dresp_data_ok=1.
REQ-013 SHALL have port busy  out  1  a transaction is outstanding.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP.
REQ-015 SHALL drive dresp_addr_ok = dreq_valid combinationally in IDLE, 0 in WAIT and RESP.
REQ-016 SHALL treat dreq_valid && dresp_addr_ok as the handshake; on that edge, capture addr, strobe, data.
REQ-017 SHALL ignore request fields outside the handshake cycle; requester may change or drop them freely.
REQ-018 SHALL index storage with addr[DEPTH_LOG2+1:2]; addr[1:0] and upper bits ignored, out-of-range addresses alias (wrap).
REQ-019 SHALL, on handshake with LATENCY=1, go IDLE->RESP; otherwise IDLE->WAIT and load counter with LATENCY-1.
REQ-020 SHALL decrement counter each WAIT cycle; WAIT->RESP when counter reaches 1 before decrement.
REQ-021 SHALL assert dresp_data_ok for exactly one cycle in RESP, exactly LATENCY cycles after the handshake edge; RESP->IDLE unconditionally.
REQ-022 SHALL, for a read, present the full 32-bit stored word on dresp_data in RESP; no lane extraction or sign extension.
REQ-023 SHALL, for a write, update only lanes with strobe bit set, on the clock edge ending RESP; dresp_data = 0 for writes.
REQ-024 SHALL drive dresp_data = 0 whenever dresp_data_ok = 0.
REQ-025 SHALL accept no new request in the RESP cycle; earliest next handshake is the cycle after data_ok (issue-to-issue minimum LATENCY+1 cycles).
REQ-026 SHALL make a read following a completed write to the same word return the written lanes merged with unchanged lanes.
REQ-027 SHALL drive busy = 1 in WAIT and RESP, 0 in IDLE.
REQ-028 SHALL hold at most one outstanding transaction.

Reset
REQ-029 SHALL, while resetn=0, force state IDLE, counter 0, captured registers 0, dresp_addr_ok/dresp_data_ok/busy = 0, dresp_data = 0.
REQ-030 SHALL discard any in-flight transaction on reset assertion; a pending write SHALL NOT modify storage.
REQ-031 SHALL NOT reset storage contents; reads of never-written words return undefined data.
REQ-032 SHALL accept a request on the first rising edge after resetn deasserts if dreq_valid=1.

Verification
REQ-033 Write 0x11223344, strobe 4'hF, addr 0x40, LATENCY=2 -> addr_ok same cycle, data_ok 2 cycles later; read 0x40 -> data 0x11223344.
REQ-034 Write 0xAABBCCDD strobe 4'b0101 to 0x40 (holding 0x11223344) -> later read returns 0x11BB33DD.
REQ-035 dreq_valid held high continuously with LATENCY=1 -> addr_ok pulses every 2nd cycle; data_ok interleaved, never coincident with addr_ok.
REQ-036 Write 0xDEADBEEF to 0x0 then read 0x400 (DEPTH_LOG2=8) -> returns 0xDEADBEEF (alias).
REQ-037 Assert resetn=0 during WAIT of a write to 0x80 (prior value 0x5) -> data_ok never asserts, outputs 0 immediately; later read 0x80 returns 0x5.
REQ-038 Change dreq_addr/data the cycle after handshake -> completed transaction uses captured values only.
